// File: rtl/ddr_cmd_scheduler.sv
// ddr_cmd_scheduler: single-entry DDR command sequencer.
// Tracks open rows per bank and gates commands on bank_monitor status.
package ddr_pkg;
  typedef enum logic [1:0] {
    ONE_BYTE,
    TWO_BYTES,
    FOUR_BYTES,
    EIGHT_BYTES
  } burst_size_t;

  typedef enum logic [1:0] {
    BANK_NOT_READY,
    BANK_FULL_READY,
    BANK_READ_READY,
    BANK_WRITE_READY
  } bank_status_t;

  typedef enum logic [3:0] {
    MODE_REGISTER_SET = 4'b0000,
    PRECHARGE         = 4'b0010,
    ACTIVE            = 4'b0011,
    WRITE             = 4'b0100,
    READ              = 4'b0101,
    NOP               = 4'b0111
  } commands_t;
endpackage

module ddr_cmd_scheduler
  import ddr_pkg::*;
#(
  parameter int ROW_W  = 13,
  parameter int COL_W  = 10,
  parameter int ADDR_W = 13,
  parameter logic [ADDR_W-1:0] MODE_REG = 13'h032
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_bank,
  input  logic [ROW_W-1:0]    req_row,
  input  logic [COL_W-1:0]    req_col,
  input  burst_size_t         req_burst,
  input  bank_status_t [3:0]  bank_status,
  output logic                CS,
  output logic                RAS,
  output logic                CAS,
  output logic                WE,
  output logic [1:0]          B,
  output logic [ADDR_W-1:0]   A,
  output burst_size_t         pool_rburst_size,
  output burst_size_t         pool_wburst_size
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_MRS_WAIT,
    ST_IDLE,
    ST_DECIDE,
    ST_SETTLE
  } state_t;

  state_t              state_q, state_d;
  commands_t           cmd_q, cmd_d;
  logic [1:0]          b_q, b_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  burst_size_t         rburst_q, rburst_d;
  burst_size_t         wburst_q, wburst_d;
  logic [3:0]          row_open_q, row_open_d;
  logic [ROW_W-1:0]    open_row_q [4];
  logic [ROW_W-1:0]    open_row_d [4];

  logic                rq_write_q, rq_write_d;
  logic [1:0]          rq_bank_q, rq_bank_d;
  logic [ROW_W-1:0]    rq_row_q, rq_row_d;
  logic [COL_W-1:0]    rq_col_q, rq_col_d;
  burst_size_t         rq_burst_q, rq_burst_d;

  logic                all_full;
  bank_status_t        tgt_status;
  logic                tgt_full;
  logic                tgt_rw_ok;
  logic                tgt_open;
  logic                tgt_hit;
  logic                take;
  logic                go_mrs;
  logic                go_rw;
  logic                go_act;
  logic                go_pre;

  always_comb begin
    all_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bank_status[i] != BANK_FULL_READY) all_full = 1'b0;
    end
  end

  assign tgt_status = bank_status[rq_bank_q];
  assign tgt_full   = tgt_status == BANK_FULL_READY;
  assign tgt_rw_ok  = tgt_full ||
                      (rq_write_q ? tgt_status == BANK_WRITE_READY
                                  : tgt_status == BANK_READ_READY);
  assign tgt_open   = row_open_q[rq_bank_q];
  assign tgt_hit    = tgt_open &&
                      (open_row_q[rq_bank_q] == rq_row_q);

  // Status is only consulted outside SETTLE, so these never fire there
  assign take   = (state_q == ST_IDLE) && req_valid;
  assign go_mrs = (state_q == ST_INIT) && all_full;
  assign go_rw  = (state_q == ST_DECIDE) && tgt_hit && tgt_rw_ok;
  assign go_act = (state_q == ST_DECIDE) && !tgt_open && tgt_full;
  assign go_pre = (state_q == ST_DECIDE) && tgt_open && !tgt_hit &&
                  all_full;

  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: begin
        if (go_mrs) state_d = ST_SETTLE;
      end
      ST_MRS_WAIT: begin
        if (all_full) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (take) state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (go_rw || go_act || go_pre) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        case (cmd_q)
          MODE_REGISTER_SET: state_d = ST_MRS_WAIT;
          READ, WRITE:       state_d = ST_IDLE;
          default:           state_d = ST_DECIDE;
        endcase
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    cmd_d      = NOP;
    b_d        = b_q;
    a_d        = a_q;
    rburst_d   = rburst_q;
    wburst_d   = wburst_q;
    row_open_d = row_open_q;
    open_row_d = open_row_q;
    rq_write_d = rq_write_q;
    rq_bank_d  = rq_bank_q;
    rq_row_d   = rq_row_q;
    rq_col_d   = rq_col_q;
    rq_burst_d = rq_burst_q;

    if (take) begin
      rq_write_d = req_write;
      rq_bank_d  = req_bank;
      rq_row_d   = req_row;
      rq_col_d   = req_col;
      rq_burst_d = req_burst;
    end

    unique case (1'b1)
      go_mrs: begin
        cmd_d = MODE_REGISTER_SET;
        b_d   = '0;
        a_d   = MODE_REG;
      end
      go_rw: begin
        cmd_d = rq_write_q ? WRITE : READ;
        b_d   = rq_bank_q;
        a_d   = ADDR_W'(rq_col_q);
        if (rq_write_q) wburst_d = rq_burst_q;
        else            rburst_d = rq_burst_q;
      end
      go_act: begin
        cmd_d = ACTIVE;
        b_d   = rq_bank_q;
        a_d   = ADDR_W'(rq_row_q);
        row_open_d[rq_bank_q] = 1'b1;
        open_row_d[rq_bank_q] = rq_row_q;
      end
      go_pre: begin
        // A10 high: precharge closes every bank
        cmd_d      = PRECHARGE;
        b_d        = rq_bank_q;
        a_d        = '0;
        a_d[10]    = 1'b1;
        row_open_d = '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cmd_q      <= NOP;
      b_q        <= '0;
      a_q        <= '0;
      rburst_q   <= ONE_BYTE;
      wburst_q   <= ONE_BYTE;
      row_open_q <= '0;
      rq_write_q <= 1'b0;
      rq_bank_q  <= '0;
      rq_row_q   <= '0;
      rq_col_q   <= '0;
      rq_burst_q <= ONE_BYTE;
    end else begin
      cmd_q      <= cmd_d;
      b_q        <= b_d;
      a_q        <= a_d;
      rburst_q   <= rburst_d;
      wburst_q   <= wburst_d;
      row_open_q <= row_open_d;
      rq_write_q <= rq_write_d;
      rq_bank_q  <= rq_bank_d;
      rq_row_q   <= rq_row_d;
      rq_col_q   <= rq_col_d;
      rq_burst_q <= rq_burst_d;
    end
  end

  always_ff @(posedge clk) begin
    open_row_q <= open_row_d;
  end

  assign {CS, RAS, CAS, WE} = cmd_q;
  assign B                  = b_q;
  assign A                  = a_q;
  assign pool_rburst_size   = rburst_q;
  assign pool_wburst_size   = wburst_q;
  assign req_ready          = state_q == ST_IDLE;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// tb_ddr_cmd_scheduler: random requests and bank status checked against
// a transaction-level model of the command sequencing rules.
module tb_ddr_cmd_scheduler;
  import ddr_pkg::*;

  localparam int ROW_W  = 13;
  localparam int COL_W  = 10;
  localparam int ADDR_W = 13;
  localparam logic [ADDR_W-1:0] MODE_REG = 13'h032;

  logic               clk = 1'b0;
  logic               n_rst;
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [1:0]         req_bank;
  logic [ROW_W-1:0]   req_row;
  logic [COL_W-1:0]   req_col;
  burst_size_t        req_burst;
  bank_status_t [3:0] bank_status;
  logic               CS, RAS, CAS, WE;
  logic [1:0]         B;
  logic [ADDR_W-1:0]  A;
  burst_size_t        pool_rburst_size;
  burst_size_t        pool_wburst_size;

  always #5 clk = ~clk;

  ddr_cmd_scheduler #(
    .ROW_W(ROW_W),
    .COL_W(COL_W),
    .ADDR_W(ADDR_W),
    .MODE_REG(MODE_REG)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_bank(req_bank),
    .req_row(req_row),
    .req_col(req_col),
    .req_burst(req_burst),
    .bank_status(bank_status),
    .CS(CS),
    .RAS(RAS),
    .CAS(CAS),
    .WE(WE),
    .B(B),
    .A(A),
    .pool_rburst_size(pool_rburst_size),
    .pool_wburst_size(pool_wburst_size)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef enum int {M_BOOT, M_MRSW, M_FREE, M_BUSY} mphase_t;

  mphase_t           ph;
  mphase_t           after;
  bit                settle;
  commands_t         e_cmd;
  int                e_b;
  int                e_a;
  burst_size_t       e_rb;
  burst_size_t       e_wb;
  bit                m_open [4];
  int                m_row  [4];
  bit                r_w;
  int                r_bank;
  int                r_row;
  int                r_col;
  burst_size_t       r_burst;

  task automatic issue(input commands_t c, input int b, input int a,
                       input mphase_t nx);
    e_cmd  = c;
    e_b    = b;
    e_a    = a;
    settle = 1'b1;
    after  = nx;
  endtask

  // One clock edge of the reference, using the inputs the DUT will sample
  task automatic model_edge();
    bit allf;
    bank_status_t st;
    allf = 1'b1;
    for (int i = 0; i < 4; i++)
      if (bank_status[i] != BANK_FULL_READY) allf = 1'b0;
    if (!n_rst) begin
      ph = M_BOOT;
      settle = 1'b0;
      e_cmd = NOP;
      e_b = 0;
      e_a = 0;
      e_rb = ONE_BYTE;
      e_wb = ONE_BYTE;
      for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
      return;
    end
    e_cmd = NOP;
    if (settle) begin
      settle = 1'b0;
      ph = after;
      return;
    end
    case (ph)
      M_BOOT: if (allf) issue(MODE_REGISTER_SET, 0, int'(MODE_REG), M_MRSW);
      M_MRSW: if (allf) ph = M_FREE;
      M_FREE: begin
        if (req_valid) begin
          r_w = req_write;
          r_bank = int'(req_bank);
          r_row = int'(req_row);
          r_col = int'(req_col);
          r_burst = req_burst;
          ph = M_BUSY;
        end
      end
      M_BUSY: begin
        st = bank_status[r_bank];
        if (m_open[r_bank] && m_row[r_bank] == r_row) begin
          if (st == BANK_FULL_READY ||
              st == (r_w ? BANK_WRITE_READY : BANK_READ_READY)) begin
            issue(r_w ? WRITE : READ, r_bank, r_col, M_FREE);
            if (r_w) e_wb = r_burst;
            else     e_rb = r_burst;
          end
        end else if (!m_open[r_bank]) begin
          if (st == BANK_FULL_READY) begin
            issue(ACTIVE, r_bank, r_row, M_BUSY);
            m_open[r_bank] = 1'b1;
            m_row[r_bank] = r_row;
          end
        end else if (allf) begin
          issue(PRECHARGE, r_bank, 1 << 10, M_BUSY);
          for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
        end
      end
      default: ph = M_BOOT;
    endcase
  endtask

  initial begin
    int resets;
    int stall;
    int sbank;
    int rw_seen;
    int r;
    logic [3:0] bus;
    resets = 0;
    stall = 0;
    sbank = 0;
    rw_seen = 0;
    n_rst = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_bank = '0;
    req_row = '0;
    req_col = '0;
    req_burst = ONE_BYTE;
    for (int i = 0; i < 4; i++) bank_status[i] = BANK_FULL_READY;
    model_edge();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      bus = {CS, RAS, CAS, WE};
      chk("cmd", 32'(bus), 32'(e_cmd));
      if (e_cmd != NOP) begin
        chk("B", 32'(B), 32'(e_b));
        chk("A", 32'(A), 32'(e_a));
      end
      chk("req_ready", 32'(req_ready), 32'(ph == M_FREE && !settle));
      chk("rburst", 32'(pool_rburst_size), 32'(e_rb));
      chk("wburst", 32'(pool_wburst_size), 32'(e_wb));
      if (bus == READ || bus == WRITE) rw_seen++;

      n_rst = 1'b1;
      if (cyc < 2) n_rst = 1'b0;
      else if (cyc > 300 && resets < 3 && e_cmd == ACTIVE &&
               $urandom_range(0, 3) == 0) begin
        n_rst = 1'b0;
        resets++;
      end

      req_valid = $urandom_range(0, 2) != 0;
      req_write = 1'($urandom_range(0, 1));
      req_bank = 2'($urandom_range(0, 3));
      req_row = ROW_W'($urandom_range(0, 3));
      req_col = COL_W'($urandom);
      req_burst = burst_size_t'(2'($urandom_range(0, 3)));

      if (stall > 0) begin
        stall--;
        for (int i = 0; i < 4; i++) bank_status[i] = BANK_FULL_READY;
        bank_status[sbank] = BANK_NOT_READY;
      end else if ($urandom_range(0, 99) < 2) begin
        stall = 20;
        sbank = int'($urandom_range(0, 3));
        for (int i = 0; i < 4; i++) bank_status[i] = BANK_FULL_READY;
        bank_status[sbank] = BANK_NOT_READY;
      end else begin
        for (int i = 0; i < 4; i++) begin
          r = int'($urandom_range(0, 9));
          bank_status[i] = r < 6  ? BANK_FULL_READY  :
                           r == 6 ? BANK_READ_READY  :
                           r == 7 ? BANK_WRITE_READY :
                                    BANK_NOT_READY;
        end
      end
      model_edge();
    end

    chk("rw_progress", 32'(rw_seen > 50), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
